itr_ctrl: RTL and testbench

ITR_CTRL -- requirements
Module: itr_ctrl

---
 rtl/itr_ctrl_pkg.sv | 16 +
 rtl/itr_ctrl_if.sv | 37 +++
 rtl/itr_ctrl_prio_enc.sv | 27 ++
 rtl/itr_ctrl.sv | 121 ++++++++++++
 tb/tb_itr_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/itr_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
// Holds the FSM state encoding and the default I/O addresses of the mask and
// acknowledge registers.
package itr_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFire    = 2'd1,
    StService = 2'd2,
    StGuard   = 2'd3
  } state_e;

  localparam int unsigned MskAddDefault = 6;
  localparam int unsigned AckAddDefault = 7;

endpackage

// File: rtl/itr_ctrl_if.sv
// Bus between the core, the interrupt sources and the interrupt controller.
//   src      : interrupt request lines, bit i = source i
//   out_en   : core output strobe
//   addr_out : core output address
//   data_out : core output data
//   itr      : one-cycle interrupt pulse to the core
//   itr_id   : index of the source being serviced
//   busy     : interrupt fired or in service
// master = core/source side, slave = controller side.
interface itr_ctrl_if #(
  parameter int unsigned NSRC   = 4,
  parameter int unsigned NUBITS = 32,
  parameter int unsigned NUIOOU = 8
) ();

  localparam int unsigned IdW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned AW  = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

  logic [NSRC-1:0]   src;
  logic              out_en;
  logic [AW-1:0]     addr_out;
  logic [NUBITS-1:0] data_out;
  logic              itr;
  logic [IdW-1:0]    itr_id;
  logic              busy;

  modport master (
    output src, out_en, addr_out, data_out,
    input  itr, itr_id, busy
  );

  modport slave (
    input  src, out_en, addr_out, data_out,
    output itr, itr_id, busy
  );

endinterface

// File: rtl/itr_ctrl_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit of req_i.
//   req_i : request vector
//   idx_o : index of the lowest set bit (0 when none)
//   vld_o : at least one request set
module prio_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]                       req_i,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o,
  output logic                               vld_o
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  // Scan from the top so the lowest index is assigned last and wins.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IdxW'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/itr_ctrl.sv
// Interrupt controller: edge-detects NSRC request lines into a pending set,
// gates them with a core-written mask, and fires one interrupt at a time to the
// core, lowest index first. The core acknowledges by writing ACKADD, after
// which NGUARD idle cycles pass before the next interrupt may fire.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of itr_ctrl_if (src/out_en/addr_out/data_out in,
//              itr/itr_id/busy out)
module itr_ctrl
  import itr_ctrl_pkg::*;
#(
  parameter int unsigned NSRC   = 4,
  parameter int unsigned NUBITS = 32,
  parameter int unsigned NUIOOU = 8,
  parameter int unsigned MSKADD = MskAddDefault,
  parameter int unsigned ACKADD = AckAddDefault,
  parameter int unsigned NGUARD = 4
) (
  input  logic      clk,
  input  logic      rst,
  itr_ctrl_if.slave bus
);

  localparam int unsigned IdW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned AW  = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
  localparam int unsigned GW  = (NGUARD > 1) ? $clog2(NGUARD) : 1;

  state_e            state_q, state_d;
  logic [NSRC-1:0]   pending_q, pending_d;
  logic [NSRC-1:0]   mask_q, mask_d;
  logic [NSRC-1:0]   src_prev_q;
  logic              hist_vld_q;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [IdW-1:0]    id_q, id_d;

  logic [NSRC-1:0]   src_rise;
  logic [NSRC-1:0]   ack_clr;
  logic [NSRC-1:0]   eligible;
  logic [IdW-1:0]    win_idx;
  logic              win_vld;
  logic              msk_wr;
  logic              ack_wr;
  logic              unused_data;

  assign unused_data = ^bus.data_out;

  assign msk_wr = bus.out_en && (bus.addr_out == AW'(MSKADD));
  assign ack_wr = bus.out_en && (bus.addr_out == AW'(ACKADD));

  // History is invalid on the first cycle after reset so a line already high
  // when reset releases is not mistaken for an edge.
  assign src_rise = bus.src & ~src_prev_q & {NSRC{hist_vld_q}};
  assign eligible = pending_q & mask_q;

  prio_enc #(
    .N (NSRC)
  ) u_prio_enc (
    .req_i (eligible),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    gcnt_d  = gcnt_q;
    ack_clr = '0;
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          id_d    = win_idx;
          state_d = StFire;
        end
      end
      StFire: state_d = StService;
      StService: begin
        if (ack_wr) begin
          ack_clr[id_q] = 1'b1;
          gcnt_d        = GW'(NGUARD - 1);
          state_d       = StGuard;
        end
      end
      StGuard: begin
        if (gcnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A new edge beats a simultaneous ack clear.
  assign pending_d = (pending_q & ~ack_clr) | src_rise;
  assign mask_d    = msk_wr ? bus.data_out[NSRC-1:0] : mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      mask_q     <= '0;
      src_prev_q <= '0;
      hist_vld_q <= 1'b0;
      gcnt_q     <= '0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      src_prev_q <= bus.src;
      hist_vld_q <= 1'b1;
      gcnt_q     <= gcnt_d;
      id_q       <= id_d;
    end
  end

  assign bus.itr    = (state_q == StFire);
  assign bus.busy   = (state_q == StFire) || (state_q == StService);
  assign bus.itr_id = id_q;

endmodule

// File: tb/tb_itr_ctrl.sv
// Bench for itr_ctrl: directed scenarios followed by random traffic, every
// cycle compared against a cycle-level reference model of the controller.
module tb_itr_ctrl;

  localparam int unsigned NSRC   = 4;
  localparam int unsigned NUBITS = 32;
  localparam int unsigned NUIOOU = 8;
  localparam int unsigned NGUARD = 4;
  localparam int          MSK    = 6;
  localparam int          ACK    = 7;

  logic clk = 1'b0;
  logic rst;

  itr_ctrl_if #(.NSRC(NSRC), .NUBITS(NUBITS), .NUIOOU(NUIOOU)) bus ();

  itr_ctrl #(
    .NSRC   (NSRC),
    .NUBITS (NUBITS),
    .NUIOOU (NUIOOU),
    .MSKADD (MSK),
    .ACKADD (ACK),
    .NGUARD (NGUARD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending/mask sets plus "firing", "in service" and
  // "guard cycles still to wait".
  bit [3:0] m_pend, m_mask, m_prev;
  bit       m_hist;
  bit       m_fire, m_svc;
  int       m_guard;
  int       m_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input bit r, input bit [3:0] s, input bit oe, input int a,
                            input bit [31:0] d);
    bit [3:0] np, nm;
    bit       nf, ns, ack;
    int       ng, nid, w;
    if (r) begin
      m_pend = '0; m_mask = '0; m_prev = '0; m_hist = 0;
      m_fire = 0; m_svc = 0; m_guard = 0; m_id = 0;
      return;
    end
    np = m_pend; nm = m_mask; nf = m_fire; ns = m_svc; ng = m_guard; nid = m_id;
    ack = oe && (a == ACK) && m_svc;
    if (ack) np[m_id] = 1'b0;
    if (m_hist) np = np | (s & ~m_prev);
    if (oe && a == MSK) nm = d[3:0];
    w = lowest(m_pend & m_mask);
    if (m_fire) begin
      nf = 0; ns = 1;
    end else if (m_svc) begin
      if (ack) begin ns = 0; ng = NGUARD; end
    end else if (m_guard > 0) begin
      ng = m_guard - 1;
    end else if (w >= 0) begin
      nf = 1; nid = w;
    end
    m_pend = np; m_mask = nm; m_fire = nf; m_svc = ns; m_guard = ng; m_id = nid;
    m_prev = s; m_hist = 1;
  endtask

  task automatic step(input bit r, input bit [3:0] s, input bit oe, input int a,
                      input bit [31:0] d);
    rst          = r;
    bus.src      = s;
    bus.out_en   = oe;
    bus.addr_out = 3'(a);
    bus.data_out = d;
    @(posedge clk);
    model_step(r, s, oe, a, d);
    #1;
    chk("itr", 32'(bus.itr), 32'(m_fire));
    chk("busy", 32'(bus.busy), 32'(m_fire | m_svc));
    chk("itr_id", 32'(bus.itr_id), 32'(m_id));
    chk("pending", 32'(dut.pending_q), 32'(m_pend));
    chk("mask", 32'(dut.mask_q), 32'(m_mask));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'b0, 0, 0, 0);
  endtask

  task automatic ack_and_drain();
    step(0, 4'b0, 1, ACK, 0);
    idle(NGUARD + 1);
  endtask

  initial begin
    bit [3:0] s;
    bit       r, oe;
    int       a;
    bit [31:0] d;

    step(1, 4'b0, 0, 0, 0);
    step(1, 4'b0, 0, 0, 0);
    chk("rst_itr", 32'(bus.itr), 0);
    chk("rst_busy", 32'(bus.busy), 0);

    // Single source, latency of two cycles, busy held until ack.
    step(0, 4'b0, 1, MSK, 32'h1);
    idle(5);
    step(0, 4'b0001, 0, 0, 0);
    chk("lat_n1_itr", 32'(bus.itr), 0);
    step(0, 4'b0, 0, 0, 0);
    chk("lat_n2_itr", 32'(bus.itr), 1);
    chk("lat_n2_id", 32'(bus.itr_id), 0);
    step(0, 4'b0, 0, 0, 0);
    chk("pulse_len", 32'(bus.itr), 0);
    idle(3);
    chk("svc_busy", 32'(bus.busy), 1);
    step(0, 4'b0, 1, ACK, 0);
    chk("guard_busy", 32'(bus.busy), 0);
    idle(NGUARD + 1);

    // Two simultaneous edges: lowest index first, second after the guard.
    step(0, 4'b0, 1, MSK, 32'hF);
    step(0, 4'b0110, 0, 0, 0);
    step(0, 4'b0, 0, 0, 0);
    chk("prio_first", 32'(bus.itr_id), 1);
    idle(2);
    step(0, 4'b0, 1, ACK, 0);
    idle(NGUARD);
    chk("guard_no_itr", 32'(bus.itr), 0);
    step(0, 4'b0, 0, 0, 0);
    chk("prio_second_itr", 32'(bus.itr), 1);
    chk("prio_second_id", 32'(bus.itr_id), 2);
    step(0, 4'b0, 0, 0, 0);
    ack_and_drain();

    // Masked edge stays pending and fires after unmasking.
    step(0, 4'b0, 1, MSK, 32'h0);
    step(0, 4'b1000, 0, 0, 0);
    step(0, 4'b0, 0, 0, 0);
    idle(3);
    chk("masked_quiet", 32'(bus.itr), 0);
    step(0, 4'b0, 1, MSK, 32'h8);
    chk("unmask_n1", 32'(bus.itr), 0);
    step(0, 4'b0, 0, 0, 0);
    chk("unmask_n2_itr", 32'(bus.itr), 1);
    chk("unmask_n2_id", 32'(bus.itr_id), 3);
    step(0, 4'b0, 0, 0, 0);
    ack_and_drain();

    // Edge coincident with its own ack keeps the request pending.
    step(0, 4'b0, 1, MSK, 32'h1);
    step(0, 4'b0001, 0, 0, 0);
    step(0, 4'b0, 0, 0, 0);
    step(0, 4'b0, 0, 0, 0);
    step(0, 4'b0001, 1, ACK, 0);
    chk("set_wins", 32'(dut.pending_q[0]), 1);
    idle(NGUARD);
    step(0, 4'b0, 0, 0, 0);
    chk("refire_itr", 32'(bus.itr), 1);
    chk("refire_id", 32'(bus.itr_id), 0);
    step(0, 4'b0, 0, 0, 0);
    ack_and_drain();

    // Ack in idle has no effect; reset in service clears everything.
    step(0, 4'b0, 1, ACK, 0);
    chk("idle_ack_busy", 32'(bus.busy), 0);
    step(0, 4'b0, 1, MSK, 32'hF);
    step(0, 4'b0100, 0, 0, 0);
    step(0, 4'b0, 0, 0, 0);
    step(0, 4'b0, 0, 0, 0);
    chk("pre_rst_busy", 32'(bus.busy), 1);
    step(1, 4'b1111, 0, 0, 0);
    chk("rst_svc_busy", 32'(bus.busy), 0);
    chk("rst_svc_id", 32'(bus.itr_id), 0);
    chk("rst_svc_pend", 32'(dut.pending_q), 0);
    chk("rst_svc_mask", 32'(dut.mask_q), 0);
    // Lines high across reset release are not edges.
    step(0, 4'b1111, 0, 0, 0);
    step(0, 4'b1111, 0, 0, 0);
    chk("held_no_edge", 32'(dut.pending_q), 0);
    step(0, 4'b0, 0, 0, 0);

    // Random traffic.
    s = '0;
    for (int n = 0; n < 800; n++) begin
      r = ($urandom_range(0, 99) == 0);
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) s[b] = ~s[b];
      oe = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0, 1:    a = ACK;
        2:       a = MSK;
        default: a = int'($urandom_range(0, 7));
      endcase
      d = $urandom;
      step(r, s, oe, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
